// File: rtl/amo_responder.sv
// AMO responder: runs one AMO as a read-modify-write (LR: read, SC: write) on a single memory port; keeps one LR/SC reservation.
// Ack comes one cycle after the final grant/rvalid; memory backpressure is by holding mem_req_o until mem_gnt_i.
module amo_responder #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned PLEN = 56
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              amo_req_i,
  input  logic [3:0]        amo_op_i,
  input  logic [1:0]        amo_size_i,
  input  logic [PLEN-1:0]   amo_addr_i,
  input  logic [XLEN-1:0]   amo_wdata_i,
  output logic              amo_ack_o,
  output logic [XLEN-1:0]   amo_result_o,
  input  logic              clear_resv_i,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic              mem_we_o,
  output logic [PLEN-1:0]   mem_addr_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  localparam int unsigned BEW  = XLEN / 8;
  localparam int unsigned OFFS = (XLEN == 64) ? 3 : 2;
  localparam logic [BEW-1:0] BE_LO = BEW'(4'hF);
  localparam logic [BEW-1:0] BE_HI = BE_LO << 4;

  typedef enum logic [3:0] {
    AMO_NONE = 4'd0, AMO_LR = 4'd1, AMO_SC = 4'd2, AMO_SWAP = 4'd3,
    AMO_ADD = 4'd4, AMO_AND = 4'd5, AMO_OR = 4'd6, AMO_XOR = 4'd7,
    AMO_MAX = 4'd8, AMO_MAXU = 4'd9, AMO_MIN = 4'd10, AMO_MINU = 4'd11
  } amo_t;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP} state_t;

  state_t            state_q;
  amo_t              op_q;
  logic              word_q;
  logic [PLEN-1:2]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   old_q;
  logic              resv_vld_q;
  logic [PLEN-4:0]   resv_addr_q;

  amo_t              req_op;
  logic              req_word;
  logic [BEW-1:0]    req_be;
  logic [XLEN-1:0]   sc_wdat;
  logic              sc_hit;
  logic              lane_hi;
  logic [31:0]       rd_w;
  logic [XLEN-1:0]   opa;
  logic [XLEN-1:0]   opb;
  logic [XLEN-1:0]   new_val;
  logic [XLEN-1:0]   wr_dat;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^amo_addr_i[1:0];

  assign req_op   = amo_t'(amo_op_i);
  assign req_word = (XLEN == 32) || (amo_size_i != 2'b11);
  assign sc_hit   = resv_vld_q && (resv_addr_q == amo_addr_i[PLEN-1:3]);
  assign sc_wdat  = req_word ? {(XLEN/32){amo_wdata_i[31:0]}} : amo_wdata_i;

  always_comb begin
    req_be = '1;
    if (req_word) req_be = ((XLEN == 64) && amo_addr_i[2]) ? BE_HI : BE_LO;
  end

  // Word operands are sign-extended to XLEN so one signed/unsigned compare serves both sizes.
  assign lane_hi = (XLEN == 64) && addr_q[2];
  assign rd_w    = lane_hi ? mem_rdata_i[XLEN-1 -: 32] : mem_rdata_i[31:0];
  assign opa     = word_q ? XLEN'(signed'(rd_w)) : mem_rdata_i;
  assign opb     = word_q ? XLEN'(signed'(wdata_q[31:0])) : wdata_q;

  always_comb begin
    new_val = opa;
    case (op_q)
      AMO_SWAP: new_val = opb;
      AMO_ADD:  new_val = opa + opb;
      AMO_AND:  new_val = opa & opb;
      AMO_OR:   new_val = opa | opb;
      AMO_XOR:  new_val = opa ^ opb;
      AMO_MAX:  new_val = ($signed(opa) < $signed(opb)) ? opb : opa;
      AMO_MAXU: new_val = (opa < opb) ? opb : opa;
      AMO_MIN:  new_val = ($signed(opa) < $signed(opb)) ? opa : opb;
      AMO_MINU: new_val = (opa < opb) ? opa : opb;
      default:  new_val = opa;
    endcase
  end

  // Word results are replicated into both lanes; the byte enables pick the live one.
  assign wr_dat = word_q ? {(XLEN/32){new_val[31:0]}} : new_val;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      op_q         <= AMO_NONE;
      word_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      old_q        <= '0;
      resv_vld_q   <= 1'b0;
      resv_addr_q  <= '0;
      amo_ack_o    <= 1'b0;
      amo_result_o <= '0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_be_o     <= '0;
      mem_wdata_o  <= '0;
    end else begin
      amo_ack_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (amo_req_i) begin
            op_q       <= req_op;
            word_q     <= req_word;
            addr_q     <= amo_addr_i[PLEN-1:2];
            wdata_q    <= amo_wdata_i;
            mem_addr_o <= {amo_addr_i[PLEN-1:OFFS], {OFFS{1'b0}}};
            mem_be_o   <= req_be;
            case (req_op)
              AMO_LR, AMO_SWAP, AMO_ADD, AMO_AND, AMO_OR, AMO_XOR,
              AMO_MAX, AMO_MAXU, AMO_MIN, AMO_MINU: begin
                mem_req_o <= 1'b1;
                mem_we_o  <= 1'b0;
                state_q   <= RD_REQ;
              end
              AMO_SC: begin
                resv_vld_q <= 1'b0;
                if (sc_hit) begin
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= 1'b1;
                  mem_wdata_o <= sc_wdat;
                  state_q     <= WR_REQ;
                end else begin
                  amo_ack_o    <= 1'b1;
                  amo_result_o <= XLEN'(1);
                  state_q      <= RESP;
                end
              end
              default: begin
                amo_ack_o    <= 1'b1;
                amo_result_o <= '0;
                state_q      <= RESP;
              end
            endcase
          end
        end
        RD_REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state_q   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem_rvalid_i) begin
            old_q <= opa;
            if (op_q == AMO_LR) begin
              resv_vld_q   <= 1'b1;
              resv_addr_q  <= addr_q[PLEN-1:3];
              amo_ack_o    <= 1'b1;
              amo_result_o <= opa;
              state_q      <= RESP;
            end else begin
              mem_req_o   <= 1'b1;
              mem_we_o    <= 1'b1;
              mem_wdata_o <= wr_dat;
              state_q     <= WR_REQ;
            end
          end
        end
        WR_REQ: begin
          if (mem_gnt_i) begin
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            amo_ack_o    <= 1'b1;
            amo_result_o <= (op_q == AMO_SC) ? '0 : old_q;
            if ((op_q != AMO_SC) && (resv_addr_q == addr_q[PLEN-1:3])) resv_vld_q <= 1'b0;
            state_q      <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      // An external kill wins over an LR setting the reservation in the same cycle.
      if (clear_resv_i) resv_vld_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_amo_responder.sv
// Randomized + directed bench for amo_responder: reference model predicts results and memory contents.
module tb_amo_responder;
  localparam int XLEN = 64;
  localparam int PLEN = 56;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            amo_req_i, clear_resv_i;
  logic [3:0]      amo_op_i;
  logic [1:0]      amo_size_i;
  logic [PLEN-1:0] amo_addr_i;
  logic [63:0]     amo_wdata_i;
  logic            amo_ack_o;
  logic [63:0]     amo_result_o;
  logic            mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
  logic [PLEN-1:0] mem_addr_o;
  logic [7:0]      mem_be_o;
  logic [63:0]     mem_wdata_o, mem_rdata_i;

  always #5 clk = ~clk;

  amo_responder #(.XLEN(XLEN), .PLEN(PLEN)) dut (
    .clk_i(clk), .rst_ni(rst_n), .amo_req_i(amo_req_i), .amo_op_i(amo_op_i),
    .amo_size_i(amo_size_i), .amo_addr_i(amo_addr_i), .amo_wdata_i(amo_wdata_i),
    .amo_ack_o(amo_ack_o), .amo_result_o(amo_result_o), .clear_resv_i(clear_resv_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  int nchk = 0, npass = 0;
  int acc_cnt = 0, acc_base = 0;
  int cyc = 0, wr_gnt_cyc = -1;
  bit stall = 1'b0;

  logic [63:0] mem [longint];
  logic [63:0] ref_mem [longint];
  bit     resv_v;
  longint resv_a;

  typedef struct { logic [63:0] res; int nacc; bit wr_end; int op; } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] w);
    return {{32{w[31]}}, w};
  endfunction

  task automatic set_mem(input longint idx, input logic [63:0] v);
    mem[idx] = v;
    ref_mem[idx] = v;
  endtask

  // Reference model: architectural AMO semantics on the model memory.
  task automatic model(input int op, input bit word, input logic [63:0] addr,
                       input logic [63:0] b, output exp_t e);
    longint idx = longint'(addr[63:3]);
    bit hi = addr[2];
    logic [63:0] od = ref_mem[idx];
    logic [31:0] ow = hi ? od[63:32] : od[31:0];
    logic [31:0] bw = b[31:0];
    logic [31:0] nw;
    logic [63:0] nd;
    e.op = op; e.wr_end = 0; e.nacc = 0; e.res = 0;
    if (op == 0 || op > 11) begin
      e.res = 0;
    end else if (op == 1) begin
      e.res = word ? sx32(ow) : od; e.nacc = 1;
      resv_v = 1; resv_a = idx;
    end else if (op == 2) begin
      if (resv_v && resv_a == idx) begin
        if (!word) ref_mem[idx] = b;
        else if (hi) ref_mem[idx][63:32] = bw;
        else ref_mem[idx][31:0] = bw;
        e.res = 0; e.nacc = 1; e.wr_end = 1;
      end else e.res = 1;
      resv_v = 0;
    end else begin
      if (word) begin
        case (op)
          3: nw = bw;
          4: nw = ow + bw;
          5: nw = ow & bw;
          6: nw = ow | bw;
          7: nw = ow ^ bw;
          8: nw = (int'(ow) > int'(bw)) ? ow : bw;
          9: nw = (ow > bw) ? ow : bw;
          10: nw = (int'(ow) < int'(bw)) ? ow : bw;
          default: nw = (ow < bw) ? ow : bw;
        endcase
        if (hi) ref_mem[idx][63:32] = nw; else ref_mem[idx][31:0] = nw;
        e.res = sx32(ow);
      end else begin
        case (op)
          3: nd = b;
          4: nd = od + b;
          5: nd = od & b;
          6: nd = od | b;
          7: nd = od ^ b;
          8: nd = (longint'(od) > longint'(b)) ? od : b;
          9: nd = (od > b) ? od : b;
          10: nd = (longint'(od) < longint'(b)) ? od : b;
          default: nd = (od < b) ? od : b;
        endcase
        ref_mem[idx] = nd;
        e.res = od;
      end
      e.nacc = 2; e.wr_end = 1;
      if (resv_v && resv_a == idx) resv_v = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    amo_req_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resv_v = 0;
    exp_q.delete();
    acc_base = acc_cnt;
    rst_n = 1'b1;
  endtask

  task automatic do_amo(input int op, input bit word, input logic [63:0] addr,
                        input logic [63:0] b, output logic [63:0] res);
    exp_t e;
    bit got = 0;
    res = '0;
    model(op, word, addr, b, e);
    exp_q.push_back(e);
    amo_req_i = 1'b1; amo_op_i = op[3:0]; amo_size_i = word ? 2'b10 : 2'b11;
    amo_addr_i = addr[PLEN-1:0]; amo_wdata_i = b;
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge clk); #1;
      if (amo_ack_o) begin res = amo_result_o; got = 1; end
    end
    amo_req_i = 1'b0;
    if (!got) begin
      nchk++;
      $display("FAIL ack_timeout: op %0d addr %h got no ack, required ack within 300 cycles", op, addr);
      do_reset();
    end
  endtask

  task automatic pulse_clear();
    clear_resv_i = 1'b1;
    @(posedge clk); #1;
    clear_resv_i = 1'b0;
    resv_v = 0;
  endtask

  // Scoreboard monitor.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && amo_ack_o) begin
      if (exp_q.size() == 0) begin
        nchk++;
        $display("FAIL unexpected_ack: got ack with result %h, required no ack", amo_result_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk($sformatf("result_op%0d", mon_e.op), amo_result_o, mon_e.res);
        chk($sformatf("mem_accesses_op%0d", mon_e.op), 64'(acc_cnt - acc_base), 64'(mon_e.nacc));
        acc_base = acc_cnt;
        if (mon_e.wr_end) chk("ack_after_wr_gnt", 64'(cyc), 64'(wr_gnt_cyc));
      end
    end
  end

  // Memory responder with random grant, read latency and spurious rvalid.
  initial begin
    bit hs, hs_we, stalled, pend;
    longint hs_idx;
    logic [7:0] hs_be, s_be;
    logic [63:0] hs_wd, s_wd, rdat, tmp;
    logic [PLEN-1:0] s_addr;
    bit s_we;
    int dly;
    stalled = 0; pend = 0; dly = 0; rdat = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (rst_n && stalled && mem_req_o) begin
        chk("stall_addr", 64'(mem_addr_o), 64'(s_addr));
        chk("stall_we_be", {55'b0, mem_we_o, mem_be_o}, {55'b0, s_we, s_be});
        chk("stall_wdata", mem_wdata_o, s_wd);
      end
      stalled = rst_n && mem_req_o && !mem_gnt_i;
      s_addr = mem_addr_o; s_we = mem_we_o; s_be = mem_be_o; s_wd = mem_wdata_o;
      hs = rst_n && mem_req_o && mem_gnt_i;
      hs_we = mem_we_o; hs_idx = longint'(mem_addr_o[PLEN-1:3]);
      hs_be = mem_be_o; hs_wd = mem_wdata_o;
      @(posedge clk);
      cyc++;
      if (hs) begin
        acc_cnt++;
        if (hs_we) begin
          tmp = mem[hs_idx];
          for (int i = 0; i < 8; i++) if (hs_be[i]) tmp[8*i +: 8] = hs_wd[8*i +: 8];
          mem[hs_idx] = tmp;
          wr_gnt_cyc = cyc;
        end else begin
          pend = 1; dly = $urandom_range(0, 2); rdat = mem[hs_idx];
        end
      end
      #1;
      if (!rst_n) begin
        pend = 0; stalled = 0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      end else begin
        mem_gnt_i = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (pend) begin
          if (dly == 0) begin mem_rvalid_i = 1'b1; mem_rdata_i = rdat; pend = 0; end
          else begin dly--; mem_rvalid_i = 1'b0; mem_rdata_i = {$urandom, $urandom}; end
        end else begin
          mem_rvalid_i = ($urandom_range(0, 7) == 0);
          mem_rdata_i = {$urandom, $urandom};
        end
      end
    end
  end

  initial begin
    logic [63:0] r, a, wd;
    int op, nidle;
    bit w;
    longint idx;
    rst_n = 1'b0; amo_req_i = 1'b0; clear_resv_i = 1'b0; amo_op_i = '0;
    amo_size_i = 2'b11; amo_addr_i = '0; amo_wdata_i = '0;
    resv_v = 0; resv_a = 0;
    #12;
    chk("rst_ack", 64'(amo_ack_o), 64'd0);
    chk("rst_result", amo_result_o, 64'd0);
    chk("rst_mem_req", 64'(mem_req_o), 64'd0);
    chk("rst_mem_we", 64'(mem_we_o), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr_o), 64'd0);
    chk("rst_mem_be", 64'(mem_be_o), 64'd0);
    chk("rst_mem_wdata", mem_wdata_o, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    set_mem('h200, 64'h5);
    do_amo(4, 0, 64'h1000, 64'h3, r);
    chk("addd_result", r, 64'h5);
    chk("addd_mem", mem['h200], 64'h8);

    set_mem('h200, 64'h7FFF_FFFF_0000_0000);
    do_amo(4, 1, 64'h1004, 64'h1, r);
    chk("addw_hi_result", r, 64'h0000_0000_7FFF_FFFF);
    chk("addw_hi_mem", mem['h200], 64'h8000_0000_0000_0000);

    set_mem('h400, 64'hAA);
    set_mem('h401, 64'h1234);
    do_amo(1, 0, 64'h2000, 64'h0, r);
    chk("lr_result", r, 64'hAA);
    do_amo(2, 0, 64'h2000, 64'h55, r);
    chk("sc_ok_result", r, 64'h0);
    chk("sc_ok_mem", mem['h400], 64'h55);
    do_amo(2, 0, 64'h2000, 64'h66, r);
    chk("sc_again_result", r, 64'h1);

    do_amo(1, 0, 64'h2000, 64'h0, r);
    pulse_clear();
    do_amo(2, 0, 64'h2000, 64'h77, r);
    chk("sc_cleared_result", r, 64'h1);
    do_amo(1, 0, 64'h2000, 64'h0, r);
    do_amo(2, 0, 64'h2008, 64'h77, r);
    chk("sc_wrong_addr_result", r, 64'h1);
    chk("sc_fail_mem", mem['h401], 64'h1234);

    set_mem('h200, 64'h0000_0000_FFFF_FFFF);
    do_amo(10, 1, 64'h1000, 64'h1, r);
    chk("minw_result", r, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("minw_mem", mem['h200], 64'h0000_0000_FFFF_FFFF);
    set_mem('h200, 64'h0000_0000_FFFF_FFFF);
    do_amo(11, 1, 64'h1000, 64'h1, r);
    chk("minuw_result", r, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("minuw_mem", mem['h200], 64'h0000_0000_0000_0001);

    // Grant stall, then reset mid-operation.
    do_amo(1, 0, 64'h2000, 64'h0, r);
    stall = 1'b1;
    @(posedge clk); #1;
    amo_req_i = 1'b1; amo_op_i = 4'd4; amo_size_i = 2'b11;
    amo_addr_i = 56'h1000; amo_wdata_i = 64'h9;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_req_held", 64'(mem_req_o), 64'd1);
      chk("stall_addr_held", 64'(mem_addr_o), 64'h1000);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("reset_mid_req", 64'(mem_req_o), 64'd0);
    chk("reset_mid_ack", 64'(amo_ack_o), 64'd0);
    amo_req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resv_v = 0;
    acc_base = acc_cnt;
    rst_n = 1'b1;
    stall = 1'b0;
    @(posedge clk); #1;
    do_amo(2, 0, 64'h2000, 64'h11, r);
    chk("sc_after_reset_result", r, 64'h1);

    for (int i = 0; i < 8; i++) set_mem('h200 + i, {$urandom, $urandom});
    for (int t = 0; t < 250; t++) begin
      op = $urandom_range(0, 11);
      w = 1'($urandom_range(0, 1));
      idx = 'h200 + longint'($urandom_range(0, 7));
      a = 64'(idx << 3);
      if (w && $urandom_range(0, 1) == 1) a[2] = 1'b1;
      wd = {$urandom, $urandom};
      do_amo(op, w, a, wd, r);
      if ($urandom_range(0, 9) == 0) pulse_clear();
      nidle = $urandom_range(0, 2);
      repeat (nidle) begin @(posedge clk); #1; end
    end

    repeat (5) @(posedge clk);
    #1;
    foreach (ref_mem[k]) chk($sformatf("final_mem_%0h", k), mem[k], ref_mem[k]);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
